// File: rtl/rtc_bus_cycle_gen.sv
// rtc_bus_cycle_gen: turns one register-access request into a complete cycle on the
// multiplexed RTC bus. The address phase comes first, then the data phase. All outputs are registered.
// Optional feature: define RTC_WRITE_VERIFY_EN to follow every write with a read-back of the
// same address and to flag a mismatch on verify_err. Without the macro verify_err is tied low.
module rtc_bus_cycle_gen #(
    parameter int unsigned T_PW   = 10,
    parameter int unsigned T_HOLD = 5,
    parameter int unsigned T_GAP  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       wr_en,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       verify_err,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    inout  wire  [7:0] dato
);

    localparam logic [7:0] PW_LOAD   = 8'(T_PW - 1);
    localparam logic [7:0] HOLD_LOAD = 8'(T_HOLD - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(T_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_REL,
        GAP,
        DATA,
        DATA_REL
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       read_pass_q, read_pass_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] dout_q, dout_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       a_d_q, a_d_d;
    logic       cs_q, cs_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic       last;
`ifdef RTC_WRITE_VERIFY_EN
    logic       verify_q, verify_d;
    logic       verr_q, verr_d;
`endif

    assign last = (cnt_q == 8'd0);

    // Phase sequencing, then pin values decoded from the next state so they register with it
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_pass_d = read_pass_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
`ifdef RTC_WRITE_VERIFY_EN
        verify_d    = verify_q;
        verr_d      = verr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    read_pass_d = ~wr_en;
                    addr_d      = addr;
                    wdata_d     = wdata;
                    state_d     = ADDR;
                    cnt_d       = PW_LOAD;
`ifdef RTC_WRITE_VERIFY_EN
                    verify_d    = 1'b0;
`endif
                end
            end
            ADDR: begin
                if (last) begin
                    state_d = ADDR_REL;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ADDR_REL: begin
                if (last) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (last) begin
                    state_d = DATA;
                    cnt_d   = PW_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DATA: begin
                if (last) begin
                    state_d = DATA_REL;
                    cnt_d   = HOLD_LOAD;
                    if (read_pass_q) begin
                        rdata_d = dato;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DATA_REL: begin
                if (last) begin
`ifdef RTC_WRITE_VERIFY_EN
                    if (!read_pass_q) begin
                        read_pass_d = 1'b1;
                        verify_d    = 1'b1;
                        state_d     = ADDR;
                        cnt_d       = PW_LOAD;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        verr_d  = verify_q & (rdata_q != wdata_q);
                    end
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        a_d_d  = 1'b1;
        cs_d   = 1'b1;
        rd_d   = 1'b1;
        wr_d   = 1'b1;
        oe_d   = 1'b0;
        dout_d = wdata_d;
        case (state_d)
            ADDR: begin
                a_d_d  = 1'b0;
                cs_d   = 1'b0;
                wr_d   = 1'b0;
                oe_d   = 1'b1;
                dout_d = addr_d;
            end
            ADDR_REL: begin
                oe_d   = 1'b1;
                dout_d = addr_d;
            end
            GAP, DATA_REL: begin
                oe_d = ~read_pass_d;
            end
            DATA: begin
                cs_d = 1'b0;
                if (read_pass_d) begin
                    rd_d = 1'b0;
                end else begin
                    wr_d = 1'b0;
                    oe_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State and registered pins; reset parks the bus with every strobe released
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            read_pass_q <= 1'b0;
            addr_q      <= 8'd0;
            wdata_q     <= 8'd0;
            rdata_q     <= 8'd0;
            dout_q      <= 8'd0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            a_d_q       <= 1'b1;
            cs_q        <= 1'b1;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
`ifdef RTC_WRITE_VERIFY_EN
            verify_q    <= 1'b0;
            verr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_pass_q <= read_pass_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            a_d_q       <= a_d_d;
            cs_q        <= cs_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
`ifdef RTC_WRITE_VERIFY_EN
            verify_q    <= verify_d;
            verr_q      <= verr_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign a_d   = a_d_q;
    assign cs    = cs_q;
    assign rd    = rd_q;
    assign wr    = wr_q;
    assign dato  = oe_q ? dout_q : 8'bzzzz_zzzz;
`ifdef RTC_WRITE_VERIFY_EN
    assign verify_err = verr_q;
`else
    assign verify_err = 1'b0;
`endif

endmodule
